// File: rtl/spi_target_if.sv
// Register bus between the SPI target and a register file.
// reg_rdata is valid one clk after reg_rd_en.
interface spi_target_if;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
        output reg_rdata
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target bridging an oversampled SPI port to a 128x8 register bus.
// Define SPI_TARGET_STATUS_EN to add a status byte shifted out during the command byte.
module spi_target #(
    parameter int   sync_stages = 2,
    parameter logic miso_idle   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ncs,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
`ifdef SPI_TARGET_STATUS_EN
    input  logic [7:0] status,
`endif
    spi_target_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

    logic [sync_stages-1:0] sclk_sync_q, sclk_sync_d;
    logic [sync_stages-1:0] mosi_sync_q, mosi_sync_d;
    logic [sync_stages-1:0] ncs_sync_q, ncs_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       armed_q, armed_d;
    logic       miso_oe_q, miso_oe_d;
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       rd_pend_q, rd_pend_d;

    logic       sclk_s, mosi_s, ncs_s;
    logic       sclk_rise, sclk_fall, byte_done;
    logic [7:0] rx_byte, status_w;

`ifdef SPI_TARGET_STATUS_EN
    assign status_w = status;
`else
    assign status_w = 8'h00;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[sync_stages-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[sync_stages-2:0], mosi};
        ncs_sync_d  = {ncs_sync_q[sync_stages-2:0], ncs};
        sclk_s      = sclk_sync_q[sync_stages-1];
        mosi_s      = mosi_sync_q[sync_stages-1];
        ncs_s       = ncs_sync_q[sync_stages-1];
        sclk_prev_d = sclk_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        rx_byte     = {rx_shift_q[6:0], mosi_s};
        byte_done   = sclk_rise & (bit_cnt_q == 3'd7);
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        rd_pend_d  = rd_en_q;
        // A frame only starts after ncs has been seen high since reset.
        armed_d    = armed_q | ncs_s;
        miso_oe_d  = ~ncs_s & armed_q;

        if (wr_en_q) addr_d = addr_q + 7'd1;
        if (rd_pend_q) tx_shift_d = bus.reg_rdata;

        if (ncs_s) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        state_d    = CMD;
                        bit_cnt_d  = 3'd0;
                        rx_shift_d = 8'h00;
                        tx_shift_d = status_w;
                    end
                end
                default: begin
                    if (sclk_rise) begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        rx_shift_d = rx_byte;
                    end else if (sclk_fall && bit_cnt_q != 3'd0 && !rd_pend_q) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        case (state_q)
                            CMD: begin
                                addr_d  = rx_byte[6:0];
                                state_d = rx_byte[7] ? WDATA : RDATA;
                                rd_en_d = ~rx_byte[7];
                            end
                            WDATA: begin
                                wdata_d = rx_byte;
                                wr_en_d = 1'b1;
                            end
                            RDATA: begin
                                addr_d  = addr_q + 7'd1;
                                rd_en_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            miso_oe_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            addr_q      <= 7'd0;
            wdata_q     <= 8'h00;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            miso_oe_q   <= miso_oe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign miso          = miso_oe_q ? tx_shift_q[7] : miso_idle;
    assign miso_oe       = miso_oe_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr_en = wr_en_q;
    assign bus.reg_rd_en = rd_en_q;
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed frames plus random frames against an array model.
// Build with SPI_TARGET_STATUS_EN defined to exercise the status byte.
module tb_spi_target;
    localparam int HALF = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ncs = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso, miso_oe;
    logic [7:0] status = 8'h00;

    always #5 clk = ~clk;

    spi_target_if bus ();

    spi_target dut (
        .clk     (clk),
        .rst     (rst),
        .ncs     (ncs),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
`ifdef SPI_TARGET_STATUS_EN
        .status  (status),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem   [128];
    logic [7:0]  model [128];
    logic [14:0] wr_q  [$];
    logic [6:0]  rd_q  [$];
    logic [7:0]  txb   [8];
    logic [7:0]  rxb   [8];

    // Register file responder and bus monitor.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i + 8'h40);
        end else begin
            if (bus.reg_wr_en) begin
                mem[bus.reg_addr] <= bus.reg_wdata;
                wr_q.push_back({bus.reg_addr, bus.reg_wdata});
            end
            if (bus.reg_rd_en) begin
                bus.reg_rdata <= mem[bus.reg_addr];
                rd_q.push_back(bus.reg_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'h1);
        check({tag, "_oe"}, 32'(miso_oe), 32'h0);
        check({tag, "_addr"}, 32'(bus.reg_addr), 32'h0);
        check({tag, "_wdata"}, 32'(bus.reg_wdata), 32'h0);
        check({tag, "_wr"}, 32'(bus.reg_wr_en), 32'h0);
        check({tag, "_rd"}, 32'(bus.reg_rd_en), 32'h0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 128; i++) model[i] = 8'(i + 8'h40);
    endtask

    task automatic spi_bits(input int k, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = txb[k][i];
            #HALF;
            rxb[k][i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int n);
        wr_q.delete();
        rd_q.delete();
        ncs = 1'b0;
        #(HALF * 2);
        for (int k = 0; k < n; k++) spi_bits(k, 8);
        #HALF;
        ncs = 1'b1;
        #(HALF * 2);
    endtask

    function automatic logic [7:0] status_exp();
`ifdef SPI_TARGET_STATUS_EN
        return status;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check_write(input int n);
        logic [6:0] a;
        logic [14:0] got;
        check("wr_count", 32'(wr_q.size()), 32'(n - 1));
        check("wr_no_rd", 32'(rd_q.size()), 32'h0);
        for (int i = 1; i < n; i++) begin
            a = txb[0][6:0] + 7'(i - 1);
            got = (i - 1 < wr_q.size()) ? wr_q[i - 1] : 'x;
            check("wr_entry", 32'(got), 32'({a, txb[i]}));
            model[a] = txb[i];
        end
    endtask

    task automatic check_read(input int n);
        logic [6:0] a;
        logic [6:0] got;
        check("rd_cmd_miso", 32'(rxb[0]), 32'(status_exp()));
        for (int i = 1; i < n; i++) begin
            a = txb[0][6:0] + 7'(i - 1);
            check("rd_miso", 32'(rxb[i]), 32'(model[a]));
        end
        check("rd_count", 32'(rd_q.size()), 32'(n));
        check("rd_no_wr", 32'(wr_q.size()), 32'h0);
        for (int i = 0; i < n; i++) begin
            a = txb[0][6:0] + 7'(i);
            got = (i < rd_q.size()) ? rd_q[i] : 'x;
            check("rd_addr", 32'(got), 32'(a));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_model();
        repeat (4) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        txb[0] = 8'h85; txb[1] = 8'h11; txb[2] = 8'h22;
        frame(3);
        check_write(3);

        status = 8'hC3;
        txb[0] = 8'h10; txb[1] = 8'h00; txb[2] = 8'hFF;
        frame(3);
        check("read_b1", 32'(rxb[1]), 32'h50);
        check("read_b2", 32'(rxb[2]), 32'h51);
        check_read(3);

        txb[0] = 8'hFF; txb[1] = 8'hAA; txb[2] = 8'hBB;
        frame(3);
        check_write(3);
        check("wrap_mem", 32'(mem[0]), 32'hBB);

        wr_q.delete();
        rd_q.delete();
        txb[0] = 8'h82; txb[1] = 8'h5C;
        ncs = 1'b0;
        #(HALF * 2);
        spi_bits(0, 8);
        spi_bits(1, 5);
        #HALF;
        ncs = 1'b1;
        #(HALF * 2);
        check("abort_no_wr", 32'(wr_q.size()), 32'h0);
        txb[0] = 8'h83; txb[1] = 8'h01;
        frame(2);
        check_write(2);

        wr_q.delete();
        rd_q.delete();
        txb[0] = 8'h84;
        ncs = 1'b0;
        #(HALF * 2);
        spi_bits(0, 3);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("midrst");
        reset_model();
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_oe_held", 32'(miso_oe), 32'h0);
        check("midrst_miso_idle", 32'(miso), 32'h1);
        check("midrst_no_strobe", 32'(wr_q.size() + rd_q.size()), 32'h0);
        ncs = 1'b1;
        #(HALF * 2);
        txb[0] = 8'h84; txb[1] = 8'h5A;
        frame(2);
        check_write(2);

        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(2, 4);
            status = 8'($urandom);
            for (int k = 0; k < 8; k++) txb[k] = 8'($urandom);
            frame(n);
            if (txb[0][7]) check_write(n);
            else check_read(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
